// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rv_pkg
// Brief   : Shared RV32I constants and types for the writeback / regfile slice
// Revision: 1.0  initial release
// ============================================================================
package rv_pkg;

  localparam int XLEN = 32;

  // Major opcodes recognised by the writeback select path
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  typedef logic [4:0] reg_addr_t;

endpackage
`default_nettype wire

// File: rtl/wb_regfile_unit_regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module  : regfile_2r1w
// Brief   : Two-read / one-write integer register file with x0 tied to zero
//           and same-cycle write-through bypass on both read ports
// Revision: 1.0  initial release
// ============================================================================
module regfile_2r1w
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  reg_addr_t       i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  reg_addr_t       i_raddr1,
  input  reg_addr_t       i_raddr2,
  output logic [XLEN-1:0] o_rdata1,
  output logic [XLEN-1:0] o_rdata2
);

  logic [XLEN-1:0] r_regs [NREGS];

  // Storage update: reset clears every entry and drops a concurrent write;
  // entry 0 is never written so it stays zero forever.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read ports: x0 is zero, a matching in-flight write is forwarded,
  // otherwise the stored value is returned. Bypass is independent of reset.
  always_comb begin
    o_rdata1 = '0;
    o_rdata2 = '0;
    if (i_raddr1 == '0) begin
      o_rdata1 = '0;
    end else if (i_we && (i_raddr1 == i_waddr)) begin
      o_rdata1 = i_wdata;
    end else begin
      o_rdata1 = r_regs[i_raddr1];
    end
    if (i_raddr2 == '0) begin
      o_rdata2 = '0;
    end else if (i_we && (i_raddr2 == i_waddr)) begin
      o_rdata2 = i_wdata;
    end else begin
      o_rdata2 = r_regs[i_raddr2];
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_regfile_unit.sv
`default_nettype none
// ============================================================================
// Module  : wb_regfile_unit
// Brief   : MEM/WB consumer: writeback select, register file write, retired
//           instruction counter and a registered writeback trace
// Revision: 1.0  initial release
// ============================================================================
module wb_regfile_unit
  import rv_pkg::*;
#(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int NREGS = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid_in,
  input  logic [XLEN-1:0]  result_in_wb,
  input  logic [XLEN-1:0]  read_data_in_wb,
  input  logic             mem_to_reg_in_wb,
  input  reg_addr_t        rd_in_wb,
  input  logic             reg_write_in_wb,
  input  logic [XLEN-1:0]  imm_in_wb,
  input  logic [6:0]       op_in_wb,
  input  logic             U_type_in_wb,
  input  logic             jump_in_wb,
  input  logic [XLEN-1:0]  pc4_in_wb,
  input  reg_addr_t        rs1_addr,
  input  reg_addr_t        rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_we,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             trace_valid,
  output reg_addr_t        trace_rd,
  output logic [XLEN-1:0]  trace_data
);

  logic [XLEN-1:0]  w_wb_data;
  logic             w_wb_we;
  logic [CNT_W-1:0] r_retired_cnt;
  logic             r_trace_valid;
  reg_addr_t        r_trace_rd;
  logic [XLEN-1:0]  r_trace_data;

  // Writeback value select; jump link wins, then LUI immediate, then the
  // AUIPC result, then load data, else the ALU result.
  always_comb begin
    w_wb_data = result_in_wb;
    if (jump_in_wb) begin
      w_wb_data = pc4_in_wb;
    end else if (U_type_in_wb) begin
      w_wb_data = (op_in_wb == OP_LUI) ? imm_in_wb : result_in_wb;
    end else if (mem_to_reg_in_wb) begin
      w_wb_data = read_data_in_wb;
    end
  end

  assign w_wb_we = wb_valid_in & reg_write_in_wb & (rd_in_wb != '0);

  regfile_2r1w #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_wb_we),
    .i_waddr  (rd_in_wb),
    .i_wdata  (w_wb_data),
    .i_raddr1 (rs1_addr),
    .i_raddr2 (rs2_addr),
    .o_rdata1 (rs1_data),
    .o_rdata2 (rs2_data)
  );

  // Retired counter: every valid slot counts, written or not; wraps freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired_cnt <= '0;
    end else if (wb_valid_in) begin
      r_retired_cnt <= r_retired_cnt + 1'b1;
    end
  end

  // Trace: valid pulses for each write; rd/data hold the last write seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_trace_valid <= 1'b0;
      r_trace_rd    <= '0;
      r_trace_data  <= '0;
    end else begin
      r_trace_valid <= w_wb_we;
      if (w_wb_we) begin
        r_trace_rd   <= rd_in_wb;
        r_trace_data <= w_wb_data;
      end
    end
  end

  assign wb_data     = w_wb_data;
  assign wb_we       = w_wb_we;
  assign retired_cnt = r_retired_cnt;
  assign trace_valid = r_trace_valid;
  assign trace_rd    = r_trace_rd;
  assign trace_data  = r_trace_data;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_regfile_unit
// Brief   : Directed self-checking bench for wb_regfile_unit
// Revision: 1.0  initial release
// ============================================================================
module tb_wb_regfile_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid_in;
  logic [31:0] result_in_wb;
  logic [31:0] read_data_in_wb;
  logic        mem_to_reg_in_wb;
  logic [4:0]  rd_in_wb;
  logic        reg_write_in_wb;
  logic [31:0] imm_in_wb;
  logic [6:0]  op_in_wb;
  logic        U_type_in_wb;
  logic        jump_in_wb;
  logic [31:0] pc4_in_wb;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] wb_data;
  logic        wb_we;
  logic [63:0] retired_cnt;
  logic        trace_valid;
  logic [4:0]  trace_rd;
  logic [31:0] trace_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_regfile_unit dut (
    .clk              (clk),
    .rst              (rst),
    .wb_valid_in      (wb_valid_in),
    .result_in_wb     (result_in_wb),
    .read_data_in_wb  (read_data_in_wb),
    .mem_to_reg_in_wb (mem_to_reg_in_wb),
    .rd_in_wb         (rd_in_wb),
    .reg_write_in_wb  (reg_write_in_wb),
    .imm_in_wb        (imm_in_wb),
    .op_in_wb         (op_in_wb),
    .U_type_in_wb     (U_type_in_wb),
    .jump_in_wb       (jump_in_wb),
    .pc4_in_wb        (pc4_in_wb),
    .rs1_addr         (rs1_addr),
    .rs2_addr         (rs2_addr),
    .rs1_data         (rs1_data),
    .rs2_data         (rs2_data),
    .wb_data          (wb_data),
    .wb_we            (wb_we),
    .retired_cnt      (retired_cnt),
    .trace_valid      (trace_valid),
    .trace_rd         (trace_rd),
    .trace_data       (trace_data)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid_in      = 1'b0;
    result_in_wb     = '0;
    read_data_in_wb  = '0;
    mem_to_reg_in_wb = 1'b0;
    rd_in_wb         = '0;
    reg_write_in_wb  = 1'b0;
    imm_in_wb        = '0;
    op_in_wb         = '0;
    U_type_in_wb     = 1'b0;
    jump_in_wb       = 1'b0;
    pc4_in_wb        = '0;
  endtask

  // Plain ALU write of value v to register r, one edge, then idle.
  task automatic alu_write(input logic [4:0] r, input logic [31:0] v);
    idle_inputs();
    wb_valid_in     = 1'b1;
    reg_write_in_wb = 1'b1;
    rd_in_wb        = r;
    result_in_wb    = v;
    step();
    idle_inputs();
  endtask

  task automatic read1(input logic [4:0] a, output logic [31:0] d);
    rs1_addr = a;
    #1;
    d = rs1_data;
  endtask

  logic [31:0] rd_val;

  initial begin
    idle_inputs();
    rs1_addr = '0;
    rs2_addr = '0;
    rst      = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    read1(5'd5, rd_val);
    check_eq("reset_x5", rd_val, 32'h0);
    check_eq("reset_cnt", retired_cnt, 64'd0);
    check_eq("reset_tvalid", trace_valid, 1'b0);

    // ALU write
    alu_write(5'd5, 32'h0000_1234);
    read1(5'd5, rd_val);
    check_eq("alu_x5", rd_val, 32'h1234);
    check_eq("alu_tvalid", trace_valid, 1'b1);
    check_eq("alu_trd", trace_rd, 5'd5);
    check_eq("alu_tdata", trace_data, 32'h1234);
    check_eq("alu_cnt", retired_cnt, 64'd1);

    // Jump beats U-type
    idle_inputs();
    wb_valid_in = 1'b1; reg_write_in_wb = 1'b1; rd_in_wb = 5'd1;
    jump_in_wb = 1'b1; U_type_in_wb = 1'b1; op_in_wb = 7'b0110111;
    pc4_in_wb = 32'h0000_0104; imm_in_wb = 32'hABCD_E000; result_in_wb = 32'h5;
    #1;
    check_eq("jump_wbdata", wb_data, 32'h104);
    step();
    idle_inputs();
    read1(5'd1, rd_val);
    check_eq("jump_x1", rd_val, 32'h104);

    // LUI takes the immediate
    idle_inputs();
    wb_valid_in = 1'b1; reg_write_in_wb = 1'b1; rd_in_wb = 5'd2;
    U_type_in_wb = 1'b1; op_in_wb = 7'b0110111;
    imm_in_wb = 32'hABCD_E000; result_in_wb = 32'h5; pc4_in_wb = 32'h0000_0200;
    step();
    idle_inputs();
    read1(5'd2, rd_val);
    check_eq("lui_x2", rd_val, 32'hABCD_E000);

    // AUIPC takes the result
    idle_inputs();
    wb_valid_in = 1'b1; reg_write_in_wb = 1'b1; rd_in_wb = 5'd6;
    U_type_in_wb = 1'b1; op_in_wb = 7'b0010111;
    imm_in_wb = 32'hABCD_E000; result_in_wb = 32'h5; read_data_in_wb = 32'h0BAD_0BAD;
    step();
    idle_inputs();
    read1(5'd6, rd_val);
    check_eq("auipc_x6", rd_val, 32'h5);

    // Load data
    idle_inputs();
    wb_valid_in = 1'b1; reg_write_in_wb = 1'b1; rd_in_wb = 5'd8;
    mem_to_reg_in_wb = 1'b1; read_data_in_wb = 32'hDEAD_BEEF; result_in_wb = 32'h77;
    op_in_wb = 7'b0000011;
    step();
    idle_inputs();
    read1(5'd8, rd_val);
    check_eq("load_x8", rd_val, 32'hDEAD_BEEF);
    check_eq("load_cnt", retired_cnt, 64'd5);

    // x0 protection
    idle_inputs();
    wb_valid_in = 1'b1; reg_write_in_wb = 1'b1; rd_in_wb = 5'd0;
    result_in_wb = 32'hFFFF_FFFF;
    #1;
    check_eq("x0_we", wb_we, 1'b0);
    step();
    idle_inputs();
    read1(5'd0, rd_val);
    check_eq("x0_read", rd_val, 32'h0);
    check_eq("x0_tvalid", trace_valid, 1'b0);
    check_eq("x0_trd_hold", trace_rd, 5'd8);
    check_eq("x0_tdata_hold", trace_data, 32'hDEAD_BEEF);
    check_eq("x0_cnt", retired_cnt, 64'd6);

    // Bypass on both ports
    alu_write(5'd7, 32'h11);
    idle_inputs();
    wb_valid_in = 1'b1; reg_write_in_wb = 1'b1; rd_in_wb = 5'd7; result_in_wb = 32'h22;
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    #1;
    check_eq("byp_rs1_pre", rs1_data, 32'h22);
    check_eq("byp_rs2_pre", rs2_data, 32'h22);
    step();
    idle_inputs();
    #1;
    check_eq("byp_rs1_post", rs1_data, 32'h22);
    check_eq("byp_rs2_post", rs2_data, 32'h22);
    check_eq("byp_cnt", retired_cnt, 64'd8);

    // Bubble
    idle_inputs();
    wb_valid_in = 1'b0; reg_write_in_wb = 1'b1; rd_in_wb = 5'd3; result_in_wb = 32'h99;
    step();
    idle_inputs();
    read1(5'd3, rd_val);
    check_eq("bub_x3", rd_val, 32'h0);
    check_eq("bub_cnt", retired_cnt, 64'd8);
    check_eq("bub_tvalid", trace_valid, 1'b0);

    // Reset mid-stream after 10 writes
    for (int i = 0; i < 10; i++) begin
      alu_write(5'(10 + i), 32'h100 + 32'(i));
    end
    read1(5'd19, rd_val);
    check_eq("pre_rst_x19", rd_val, 32'h109);
    check_eq("pre_rst_cnt", retired_cnt, 64'd18);
    idle_inputs();
    rst = 1'b1;
    wb_valid_in = 1'b1; reg_write_in_wb = 1'b1; rd_in_wb = 5'd4; result_in_wb = 32'h44;
    rs1_addr = 5'd4;
    #1;
    check_eq("rst_bypass", rs1_data, 32'h44);
    step();
    rst = 1'b0;
    idle_inputs();
    read1(5'd4, rd_val);
    check_eq("rst_x4", rd_val, 32'h0);
    read1(5'd5, rd_val);
    check_eq("rst_x5", rd_val, 32'h0);
    read1(5'd19, rd_val);
    check_eq("rst_x19", rd_val, 32'h0);
    check_eq("rst_cnt", retired_cnt, 64'd0);
    check_eq("rst_tvalid", trace_valid, 1'b0);
    check_eq("rst_trd", trace_rd, 5'd0);
    check_eq("rst_tdata", trace_data, 32'h0);

    // First write after reset lands normally
    alu_write(5'd4, 32'h55);
    read1(5'd4, rd_val);
    check_eq("post_rst_x4", rd_val, 32'h55);
    check_eq("post_rst_cnt", retired_cnt, 64'd1);
    check_eq("post_rst_trd", trace_rd, 5'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
